// File: rtl/vga_scanout_if.sv
// Scan-out port bundle: framebuffer read port plus the VGA DAC pins.
// master = the scan-out controller, slave = framebuffer/DAC side.
interface vga_scanout_if;
  logic [31:0] pixel_addr;
  logic [7:0]  pixel_val;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        frame_start;

  modport master (
    output pixel_addr,
    input  pixel_val,
    output vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start
  );

  modport slave (
    input  pixel_addr,
    output pixel_val,
    input  vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA raster generator with framebuffer fetch and a fixed 2-stage pin pipeline.
// Optional macro VGA_SCANOUT_RGB332_EN: decode pixel_val as RGB332 instead of grayscale.
module vga_scanout #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          IMG_W    = 256,
  parameter int          IMG_H    = 256,
  parameter int          IMG_X0   = 192,
  parameter int          IMG_Y0   = 112,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic           clk,
  input  logic           reset,
  vga_scanout_if.master  vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [31:0] HA     = H_ACTIVE;
  localparam logic [31:0] VA     = V_ACTIVE;
  localparam logic [31:0] HS_BEG = H_ACTIVE + H_FP;
  localparam logic [31:0] HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam logic [31:0] VS_BEG = V_ACTIVE + V_FP;
  localparam logic [31:0] VS_END = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [31:0] X0     = IMG_X0;
  localparam logic [31:0] Y0     = IMG_Y0;
  localparam logic [31:0] W      = IMG_W;
  localparam logic [31:0] H      = IMG_H;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
    logic in_img;
    logic fs;
  } flags_t;

  localparam flags_t FLAGS_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0, in_img: 1'b0, fs: 1'b0};

  logic [HW-1:0] hcnt, hcnt_n;
  logic [VW-1:0] vcnt, vcnt_n;
  logic          h_wrap;
  logic [31:0]   row_base, row_base_n, addr_n;
  flags_t        flags_now, flags_d1;
  logic [23:0]   pix_rgb, rgb_n;

  function automatic logic active_at(logic [HW-1:0] h, logic [VW-1:0] v);
    return (32'(h) < HA) && (32'(v) < VA);
  endfunction

  // Differences wrap to huge values left/above the window, so one compare each suffices.
  function automatic logic in_win(logic [HW-1:0] h, logic [VW-1:0] v);
    return active_at(h, v) && (32'(h) - X0 < W) && (32'(v) - Y0 < H);
  endfunction

  // The address register must match the counters in the same cycle, so it is
  // built from the next-state raster position.
  always_comb begin
    h_wrap = (hcnt == HW'(H_TOTAL - 1));
    hcnt_n = h_wrap ? '0 : hcnt + HW'(1);
    vcnt_n = vcnt;
    if (h_wrap)
      vcnt_n = (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + VW'(1);
    row_base_n = row_base;
    if (h_wrap)
      row_base_n = (32'(vcnt_n) == Y0) ? '0 : row_base + W;
    addr_n = in_win(hcnt_n, vcnt_n) ? row_base_n + (32'(hcnt_n) - X0) : '0;
  end

  always_comb begin
    flags_now        = FLAGS_IDLE;
    flags_now.hs     = !((32'(hcnt) >= HS_BEG) && (32'(hcnt) < HS_END));
    flags_now.vs     = !((32'(vcnt) >= VS_BEG) && (32'(vcnt) < VS_END));
    flags_now.active = active_at(hcnt, vcnt);
    flags_now.in_img = in_win(hcnt, vcnt);
    flags_now.fs     = (hcnt == '0) && (vcnt == '0);
  end

`ifdef VGA_SCANOUT_RGB332_EN
  assign pix_rgb = {vif.pixel_val[7:5], vif.pixel_val[7:5], vif.pixel_val[7:6],
                    vif.pixel_val[4:2], vif.pixel_val[4:2], vif.pixel_val[4:3],
                    {4{vif.pixel_val[1:0]}}};
`else
  assign pix_rgb = {3{vif.pixel_val}};
`endif

  always_comb begin
    rgb_n = '0;
    if (flags_d1.in_img)      rgb_n = pix_rgb;
    else if (flags_d1.active) rgb_n = BG_COLOR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt            <= '0;
      vcnt            <= '0;
      row_base        <= '0;
      vif.pixel_addr  <= '0;
      flags_d1        <= FLAGS_IDLE;
      vif.vga_hs      <= 1'b1;
      vif.vga_vs      <= 1'b1;
      vif.vga_blank_n <= 1'b0;
      vif.vga_r       <= '0;
      vif.vga_g       <= '0;
      vif.vga_b       <= '0;
      vif.frame_start <= 1'b0;
    end else begin
      hcnt            <= hcnt_n;
      vcnt            <= vcnt_n;
      row_base        <= row_base_n;
      vif.pixel_addr  <= addr_n;
      // stage 1: flags wait alongside the framebuffer read
      flags_d1        <= flags_now;
      // stage 2: pins, with pixel_val landing straight in the colour registers
      vif.vga_hs      <= flags_d1.hs;
      vif.vga_vs      <= flags_d1.vs;
      vif.vga_blank_n <= flags_d1.active;
      vif.frame_start <= flags_d1.fs;
      {vif.vga_r, vif.vga_g, vif.vga_b} <= rgb_n;
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// Random-stimulus scoreboard bench for vga_scanout (short vertical geometry, full-size lines).
`timescale 1ns/1ps
module tb_vga_scanout;
  localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
  localparam int VA = 8, VFP = 1, VS = 2, VBP = 2;
  localparam int IW = 256, IH = 4, X0 = 192, Y0 = 2;
  localparam logic [23:0] BG = 24'h3C5A96;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  vga_scanout_if vif();

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .IMG_W(IW), .IMG_H(IH), .IMG_X0(X0), .IMG_Y0(Y0),
    .BG_COLOR(BG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic [23:0] rgb;
    logic        fs;
  } pins_t;

  typedef struct {
    pins_t       pins;
    logic [31:0] addr;
    int          pos;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         passed = 0;
  int         mode = 0;
  int         rst_epoch = 0;
  logic [7:0] rnd_mem [1024];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic logic [7:0] ram_fn(int m, logic [31:0] a);
    case (m)
      0:       return a[7:0];
      1:       return 8'hA5;
      2:       return rnd_mem[a[9:0]];
      default: return 8'b101_011_10;
    endcase
  endfunction

  function automatic logic in_img(int p);
    int h = p % HT;
    int v = p / HT;
    return h < HA && v < VA && h >= X0 && h < X0 + IW && v >= Y0 && v < Y0 + IH;
  endfunction

  function automatic logic [31:0] model_addr(int p);
    if (!in_img(p)) return 32'd0;
    return 32'(((p / HT) - Y0) * IW + ((p % HT) - X0));
  endfunction

  function automatic logic [23:0] colour(logic [7:0] p);
`ifdef VGA_SCANOUT_RGB332_EN
    logic [2:0] r = p[7:5];
    logic [2:0] g = p[4:2];
    logic [1:0] b = p[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
`else
    return {p, p, p};
`endif
  endfunction

  // p < 0 means the pins are still showing the reset-cleared pipeline.
  function automatic pins_t exp_pins(int p, logic [7:0] val);
    pins_t e;
    int h, v;
    logic act;
    e = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, rgb: 24'h0, fs: 1'b0};
    if (p < 0) return e;
    h = p % HT;
    v = p / HT;
    act = h < HA && v < VA;
    e.hs      = !(h >= HA + HFP && h < HA + HFP + HS);
    e.vs      = !(v >= VA + VFP && v < VA + VFP + VS);
    e.blank_n = act;
    e.rgb     = in_img(p) ? colour(val) : (act ? BG : 24'h0);
    e.fs      = (p == 0);
    return e;
  endfunction

  // Synchronous framebuffer model: data for an address one cycle later.
  always @(posedge clk) vif.pixel_val <= ram_fn(mode, vif.pixel_addr);

  // Reference model: raster position = cycles since reset modulo the frame.
  initial begin : model
    int pos = 0, d1 = -1, d2 = -1;
    logic [7:0] v1 = 8'h0, v2 = 8'h0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        pos = 0; d1 = -1; d2 = -1;
        rst_epoch++;
      end else begin
        d2 = d1; v2 = v1;
        v1 = ram_fn(mode, model_addr(pos));
        d1 = pos;
        pos = (pos + 1) % FRAME;
      end
      e.pins = exp_pins(d2, v2);
      e.addr = model_addr(pos);
      e.pos  = pos;
      exp_q.push_back(e);
    end
  end

  int bhits = 0;

  initial begin : monitor
    exp_t e;
    pins_t act;
    int cyc = 0, fs_last = -1, fs_ep = -1;
    int hs_run = 0, hs_ep = 0, bl_run = 0, bl_ep = 0;
    int h, v;
    string an;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      cyc++;
      act = {vif.vga_hs, vif.vga_vs, vif.vga_blank_n, vif.vga_r, vif.vga_g, vif.vga_b, vif.frame_start};
      check("pins", 64'(act), 64'(e.pins));

      h = e.pos % HT;
      v = e.pos / HT;
      an = "addr";
      if ((v == Y0 && (h == X0 || h == X0 + IW - 1 || h == X0 - 1)) ||
          (v == Y0 + 1 && h == X0) ||
          (v == Y0 + IH - 1 && (h == X0 + IW - 1 || h == X0 + IW))) begin
        an = "addr_boundary";
        bhits++;
      end
      check(an, 64'(vif.pixel_addr), 64'(e.addr));

      if (vif.frame_start === 1'b1) begin
        if (fs_last >= 0 && fs_ep == rst_epoch) check("fs_period", 64'(cyc - fs_last), 64'(FRAME));
        fs_last = cyc;
        fs_ep = rst_epoch;
      end
      if (vif.vga_hs === 1'b0) begin
        if (hs_run == 0) hs_ep = rst_epoch;
        hs_run++;
      end else begin
        if (hs_run > 0 && hs_ep == rst_epoch) check("hs_width", 64'(hs_run), 64'(HS));
        hs_run = 0;
      end
      if (vif.vga_blank_n === 1'b1) begin
        if (bl_run == 0) bl_ep = rst_epoch;
        bl_run++;
      end else begin
        if (bl_run > 0 && bl_ep == rst_epoch) check("blank_width", 64'(bl_run), 64'(HA));
        bl_run = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin : stim
    for (int i = 0; i < 1024; i++) rnd_mem[i] = 8'($urandom);
    reset = 1'b1;
    mode = 0;
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (FRAME + 300) @(negedge clk);
    mode = 1;
    repeat ($urandom_range(3000, 8000)) @(negedge clk);
    do_reset();
    mode = 2;
    repeat (FRAME + 300) @(negedge clk);
    do_reset();
    mode = 3;
    repeat (FRAME + 300) @(negedge clk);
    check("boundary_seen", 64'(bhits >= 18), 64'd1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
